// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - program sequencer driving micro inst/data_in, capturing data_out into a result FIFO
module micro_sequencer #(
  parameter int AW = 4,
  parameter int RD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [16:0]   prog_wdata,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [7:0]    inst,
  output logic [7:0]    data_in,
  input  logic [7:0]    data_out,
  output logic          res_valid,
  output logic [7:0]    res_data,
  input  logic          res_ready
);
  localparam int LRD = $clog2(RD);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

  state_t         state;
  logic [AW-1:0]  pc;
  logic           cap_q;
  logic [16:0]    mem [0:(1<<AW)-1];
  logic [7:0]     fifo [0:RD-1];
  logic [LRD-1:0] rd_ptr;
  logic [LRD-1:0] wr_ptr;
  logic [LRD:0]   count;

  logic [16:0] word;
  logic        w_cap;
  logic [7:0]  w_din;
  logic [7:0]  w_op;
  logic        full;
  logic        push;
  logic        pop;

  assign word      = mem[pc];
  assign w_cap     = word[16];
  assign w_din     = word[15:8];
  assign w_op      = word[7:0];
  assign full      = (count == (LRD+1)'(RD));
  assign res_valid = (count != '0);
  assign res_data  = res_valid ? fifo[rd_ptr] : 8'h00;
  assign pop       = res_valid & res_ready;
  assign push      = (state == EXEC) & cap_q;
  assign busy      = (state == FETCH) || (state == EXEC);

  // Program store is deliberately not reset so it survives a mid-run reset.
  always_ff @(posedge clk) begin
    if (prog_we && state == IDLE) mem[prog_addr] <= prog_wdata;
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= data_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= '0;
      inst    <= 8'h00;
      data_in <= 8'h00;
      done    <= 1'b0;
      cap_q   <= 1'b0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          inst    <= 8'h00;
          data_in <= 8'h00;
          if (start) begin
            state <= FETCH;
            pc    <= '0;
          end
        end
        FETCH: begin
          if (w_op[7]) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (w_cap && full && !pop) begin
            state <= FETCH;
          end else begin
            inst    <= {1'b0, w_op[6:0]};
            data_in <= w_din;
            cap_q   <= w_cap;
            state   <= EXEC;
          end
        end
        EXEC: begin
          inst    <= 8'h00;
          data_in <= 8'h00;
          if (pc == '1) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            pc    <= pc + AW'(1);
            state <= FETCH;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // A capturing word only issues when a slot is free, so push never overflows.
      if (push) wr_ptr <= wr_ptr + LRD'(1);
      if (pop)  rd_ptr <= rd_ptr + LRD'(1);
      case ({push, pop})
        2'b10:   count <= count + (LRD+1)'(1);
        2'b01:   count <= count - (LRD+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - self-checking bench for micro_sequencer with a behavioural micro and program model
module tb_micro_sequencer;
  localparam int AW = 4;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [16:0]   prog_wdata = '0;
  logic          start = 1'b0;
  logic          res_ready = 1'b0;
  logic          busy, done, res_valid;
  logic [7:0]    inst, data_in, data_out, res_data;

  logic          clr = 1'b0;
  logic          tie33 = 1'b0;
  logic [7:0]    ua = 8'h00, ub = 8'h00;

  int checks = 0;
  int errors = 0;

  logic [16:0] prog [16];
  logic [7:0]  exp_i [$];
  logic [7:0]  exp_d [$];
  bit          exp_b [$];
  bit          exp_dn [$];
  logic [7:0]  exp_caps [$];

  micro_sequencer #(.AW(AW), .RD(RD)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .start(start), .busy(busy), .done(done),
    .inst(inst), .data_in(data_in), .data_out(data_out),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  // Tiny stand-in for the micro datapath: A/B registers, combinational result bus.
  always @(posedge clk) begin
    if (clr) begin
      ua <= 8'h00;
      ub <= 8'h00;
    end else begin
      case (inst)
        8'h12: ub <= data_in;
        8'h08: ua <= data_in;
        8'h48: ua <= ua + ub;
        8'h68: ua <= ua - ub;
        default: ;
      endcase
    end
  end

  always_comb begin
    data_out = 8'h00;
    case (inst)
      8'h12: data_out = data_in;
      8'h02: data_out = ub;
      8'h08: data_out = data_in;
      8'h48: data_out = ua + ub;
      8'h68: data_out = ua - ub;
      8'h01: data_out = ua;
      default: data_out = 8'h00;
    endcase
    if (tie33) data_out = 8'h33;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic ueval(input logic [6:0] op, input logic [7:0] din, input logic [7:0] a_i,
                       input logic [7:0] b_i, output logic [7:0] dout, output logic [7:0] a_o,
                       output logic [7:0] b_o);
    a_o = a_i;
    b_o = b_i;
    dout = 8'h00;
    case (op)
      7'h12: begin dout = din; b_o = din; end
      7'h02: dout = b_i;
      7'h08: begin dout = din; a_o = din; end
      7'h48: begin dout = a_i + b_i; a_o = a_i + b_i; end
      7'h68: begin dout = a_i - b_i; a_o = a_i - b_i; end
      7'h01: dout = a_i;
      default: dout = 8'h00;
    endcase
  endtask

  // Expected per-cycle trace for a run with no back-pressure: fetch, exec per word, then done.
  task automatic build_model();
    logic [7:0] a, b, dout, a2, b2;
    a = 8'h00;
    b = 8'h00;
    exp_i.delete(); exp_d.delete(); exp_b.delete(); exp_dn.delete(); exp_caps.delete();
    for (int i = 0; i < 16; i++) begin
      exp_i.push_back(8'h00); exp_d.push_back(8'h00); exp_b.push_back(1'b1); exp_dn.push_back(1'b0);
      if (prog[i][7]) break;
      exp_i.push_back({1'b0, prog[i][6:0]}); exp_d.push_back(prog[i][15:8]);
      exp_b.push_back(1'b1); exp_dn.push_back(1'b0);
      ueval(prog[i][6:0], prog[i][15:8], a, b, dout, a2, b2);
      if (prog[i][16]) exp_caps.push_back(dout);
      a = a2;
      b = b2;
    end
    exp_i.push_back(8'h00); exp_d.push_back(8'h00); exp_b.push_back(1'b0); exp_dn.push_back(1'b1);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      prog_we = 1'b1;
      prog_addr = AW'(i);
      prog_wdata = prog[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic test_prog();
    prog[0] = 17'h15512; prog[1] = 17'h10002; prog[2] = 17'h00A08; prog[3] = 17'h00048;
    prog[4] = 17'h00068; prog[5] = 17'h10001;
    for (int i = 6; i < 16; i++) prog[i] = 17'h00080;
  endtask

  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clr = 1'b0;
  endtask

  task automatic run_prog(input string tag, input bit inject);
    logic [7:0] got [$];
    build_model();
    res_ready = 1'b1;
    start_run();
    for (int k = 0; k < exp_i.size(); k++) begin
      chk({tag, " inst"}, inst, exp_i[k]);
      chk({tag, " data_in"}, data_in, exp_d[k]);
      chk({tag, " busy"}, busy, exp_b[k]);
      chk({tag, " done"}, done, exp_dn[k]);
      if (res_valid) got.push_back(res_data);
      if (inject && k == 3) begin
        prog_we = 1'b1; prog_addr = AW'(2); prog_wdata = 17'h1FFFF; start = 1'b1;
      end else begin
        prog_we = 1'b0; start = 1'b0;
      end
      @(negedge clk);
    end
    prog_we = 1'b0;
    start = 1'b0;
    repeat (4) begin
      if (res_valid) got.push_back(res_data);
      @(negedge clk);
    end
    chk({tag, " ncap"}, got.size(), exp_caps.size());
    for (int j = 0; j < got.size() && j < exp_caps.size(); j++) chk({tag, " cap"}, got[j], exp_caps[j]);
    chk({tag, " idle busy"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] expv [3];
    bit seen;
    int cnt, bad, popped;
    logic [7:0] opsel [6];
    expv[0] = 8'h55; expv[1] = 8'h55; expv[2] = 8'h0A;
    opsel[0] = 8'h12; opsel[1] = 8'h02; opsel[2] = 8'h08;
    opsel[3] = 8'h48; opsel[4] = 8'h68; opsel[5] = 8'h01;

    repeat (2) @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst inst", inst, 8'h00);
    chk("rst data_in", data_in, 8'h00);
    chk("rst res_valid", res_valid, 1'b0);
    chk("rst res_data", res_data, 8'h00);
    rst_n = 1'b1;

    test_prog();
    load_prog();
    run_prog("t1", 1'b0);

    // Results held while host is not ready, then drained in order.
    res_ready = 1'b0;
    start_run();
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("t2 done seen", seen, 1'b1);
    chk("t2 valid at done", res_valid, 1'b1);
    res_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk("t2 valid", res_valid, 1'b1);
      chk("t2 data", res_data, expv[j]);
      @(negedge clk);
    end
    chk("t2 empty", res_valid, 1'b0);

    // Back-pressure: six captures into a four-deep FIFO.
    for (int i = 0; i < 6; i++) prog[i] = 17'h10001;
    for (int i = 6; i < 16; i++) prog[i] = 17'h00080;
    load_prog();
    tie33 = 1'b1;
    res_ready = 1'b0;
    start_run();
    repeat (11) @(negedge clk);
    chk("t3 stall busy", busy, 1'b1);
    chk("t3 stall inst", inst, 8'h00);
    chk("t3 stall valid", res_valid, 1'b1);
    chk("t3 stall data", res_data, 8'h33);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (inst != 8'h00) cnt++;
      @(negedge clk);
    end
    chk("t3 one issue", cnt, 1);
    chk("t3 still busy", busy, 1'b1);
    res_ready = 1'b1;
    popped = 1;
    bad = 0;
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (done) seen = 1'b1;
      if (res_valid) begin
        popped++;
        if (res_data != 8'h33) bad++;
      end else if (seen) break;
      @(negedge clk);
    end
    chk("t3 done seen", seen, 1'b1);
    chk("t3 total pops", popped, 6);
    chk("t3 bad data", bad, 0);
    tie33 = 1'b0;

    // All sixteen words executable: stops at the last address without wrapping.
    for (int i = 0; i < 16; i++) prog[i] = 17'h00008;
    load_prog();
    run_prog("full", 1'b0);
    chk("full pc held", dut.pc, 15);

    // Reset in the middle of word 3's execute cycle.
    test_prog();
    load_prog();
    res_ready = 1'b1;
    start_run();
    repeat (7) @(negedge clk);
    chk("rmid inst w3", inst, 8'h48);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid inst", inst, 8'h00);
    chk("rmid data_in", data_in, 8'h00);
    chk("rmid busy", busy, 1'b0);
    chk("rmid valid", res_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rmid post busy", busy, 1'b0);
    chk("rmid post valid", res_valid, 1'b0);
    run_prog("after reset", 1'b0);

    run_prog("inject", 1'b1);
    run_prog("rerun", 1'b0);

    for (int r = 0; r < 8; r++) begin
      int n;
      n = (r == 0) ? 0 : int'($urandom_range(1, 15));
      for (int i = 0; i < 16; i++) begin
        logic [7:0] op;
        if ($urandom_range(0, 7) < 6) op = opsel[$urandom_range(0, 5)];
        else op = 8'($urandom_range(0, 127));
        if (i >= n) op = op | 8'h80;
        prog[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), op};
      end
      load_prog();
      run_prog($sformatf("rnd%0d", r), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
